// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: operand width,
// iteration count, controller states and the divide-by-zero quotient.
package div_pkg;

    localparam int DIV_WIDTH  = 16;
    localparam int ITER_COUNT = 16;
    localparam int CNT_WIDTH  = 5;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_DVS = 3'd1,
        PREP     = 3'd2,
        ITER     = 3'd3,
        FIX      = 3'd4,
        SIGN     = 3'd5,
        DONE     = 3'd6
    } div_state_t;

    // Sign-extend to one extra bit and take the magnitude, so -32768 becomes +32768
    function automatic logic [DIV_WIDTH:0] abs_ext(input logic [DIV_WIDTH-1:0] v);
        logic [DIV_WIDTH:0] ext;
        ext = {v[DIV_WIDTH-1], v};
        return v[DIV_WIDTH-1] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: operand capture, 17-bit non-restoring remainder/quotient
// registers, iteration counter and the final sign correction.
module div_datapath
    import div_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DIV_WIDTH-1:0] i_data_in,
    input  logic                 i_ld_dvd,
    input  logic                 i_ld_dvs,
    input  logic                 i_prep,
    input  logic                 i_step,
    input  logic                 i_fix,
    output logic [DIV_WIDTH-1:0] o_dividend,
    output logic                 o_dvs_zero,
    output logic                 o_cnt_last,
    output logic                 o_rem_neg,
    output logic [DIV_WIDTH-1:0] o_quo_signed,
    output logic [DIV_WIDTH-1:0] o_rem_signed
);

    logic [DIV_WIDTH-1:0] r_dividend;
    logic [DIV_WIDTH-1:0] r_divisor;
    logic [DIV_WIDTH:0]   r_dvs_mag;
    logic [DIV_WIDTH:0]   r_rem;
    logic [DIV_WIDTH-1:0] r_quo;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_sign_q;
    logic                 r_sign_r;

    logic [DIV_WIDTH:0]   w_shift;
    logic [DIV_WIDTH:0]   w_new_rem;
    logic [DIV_WIDTH-1:0] w_dvd_mag;
    logic [DIV_WIDTH-1:0] w_rem_low;

    // One non-restoring step: shift the quotient MSB into the remainder, then add or subtract the divisor
    always_comb begin
        w_shift   = {r_rem[DIV_WIDTH-1:0], r_quo[DIV_WIDTH-1]};
        w_new_rem = r_rem[DIV_WIDTH] ? (w_shift + r_dvs_mag) : (w_shift - r_dvs_mag);
        w_dvd_mag = r_dividend[DIV_WIDTH-1] ? (~r_dividend + 1'b1) : r_dividend;
        w_rem_low = r_rem[DIV_WIDTH-1:0];
    end

    // Operand capture, preparation, iteration and remainder fix-up
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_dvs_mag  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
        end else begin
            if (i_ld_dvd) begin
                r_dividend <= i_data_in;
            end
            if (i_ld_dvs) begin
                r_divisor <= i_data_in;
            end
            if (i_prep) begin
                r_dvs_mag <= abs_ext(r_divisor);
                r_rem     <= '0;
                r_quo     <= w_dvd_mag;
                r_cnt     <= CNT_WIDTH'(ITER_COUNT);
                r_sign_q  <= r_dividend[DIV_WIDTH-1] ^ r_divisor[DIV_WIDTH-1];
                r_sign_r  <= r_dividend[DIV_WIDTH-1];
            end
            if (i_step) begin
                r_rem <= w_new_rem;
                r_quo <= {r_quo[DIV_WIDTH-2:0], ~w_new_rem[DIV_WIDTH]};
                r_cnt <= r_cnt - 1'b1;
            end
            if (i_fix && r_rem[DIV_WIDTH]) begin
                r_rem <= r_rem + r_dvs_mag;
            end
        end
    end

    // Status back to the controller and truncating-division sign correction
    always_comb begin
        o_dividend   = r_dividend;
        o_dvs_zero   = (r_divisor == '0);
        o_cnt_last   = (r_cnt == CNT_WIDTH'(1));
        o_rem_neg    = r_rem[DIV_WIDTH];
        o_quo_signed = r_sign_q ? (~r_quo + 1'b1) : r_quo;
        o_rem_signed = r_sign_r ? (~w_rem_low + 1'b1) : w_rem_low;
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed 16-bit divider: controller FSM with registered outputs,
// driving the div_datapath through one-hot control strobes.
module seq_divider
    import div_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [DIV_WIDTH-1:0] i_data_in,
    output logic [DIV_WIDTH-1:0] o_quotient,
    output logic [DIV_WIDTH-1:0] o_remainder,
    output logic                 o_done,
    output logic                 o_busy,
    output logic                 o_div_by_zero
);

    div_state_t           r_state;
    logic [DIV_WIDTH-1:0] r_quotient;
    logic [DIV_WIDTH-1:0] r_remainder;
    logic                 r_done;
    logic                 r_busy;
    logic                 r_dbz;

    logic                 w_ld_dvd;
    logic                 w_ld_dvs;
    logic                 w_prep;
    logic                 w_step;
    logic                 w_fix;
    logic [DIV_WIDTH-1:0] w_dividend;
    logic                 w_dvs_zero;
    logic                 w_cnt_last;
    logic                 w_rem_neg;
    logic [DIV_WIDTH-1:0] w_quo_signed;
    logic [DIV_WIDTH-1:0] w_rem_signed;

    // Decode the current state into datapath strobes; a zero divisor skips preparation
    always_comb begin
        w_ld_dvd = ((r_state == IDLE) || (r_state == DONE)) && i_start;
        w_ld_dvs = (r_state == LOAD_DVS);
        w_prep   = (r_state == PREP) && !w_dvs_zero;
        w_step   = (r_state == ITER);
        w_fix    = (r_state == FIX) && w_rem_neg;
    end

    div_datapath u_datapath (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_data_in    (i_data_in),
        .i_ld_dvd     (w_ld_dvd),
        .i_ld_dvs     (w_ld_dvs),
        .i_prep       (w_prep),
        .i_step       (w_step),
        .i_fix        (w_fix),
        .o_dividend   (w_dividend),
        .o_dvs_zero   (w_dvs_zero),
        .o_cnt_last   (w_cnt_last),
        .o_rem_neg    (w_rem_neg),
        .o_quo_signed (w_quo_signed),
        .o_rem_signed (w_rem_signed)
    );

    // Controller FSM; results are latched only on entry to DONE so they stay stable until the next start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= LOAD_DVS;
                    end
                end
                LOAD_DVS: begin
                    r_state <= PREP;
                end
                PREP: begin
                    if (w_dvs_zero) begin
                        r_quotient  <= DBZ_QUOTIENT;
                        r_remainder <= w_dividend;
                        r_dbz       <= 1'b1;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_dbz   <= 1'b0;
                        r_state <= ITER;
                    end
                end
                ITER: begin
                    if (w_cnt_last) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state <= SIGN;
                end
                SIGN: begin
                    r_quotient  <= w_quo_signed;
                    r_remainder <= w_rem_signed;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_done        = r_done;
    assign o_busy        = r_busy;
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with a scoreboard of expected results.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        done;
    logic        busy;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    seq_divider dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_data_in     (data_in),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_done        (done),
        .o_busy        (busy),
        .o_div_by_zero (div_by_zero)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Run one division: push the reference result, drive both operands, wait for done, pop and compare
    task automatic applyStimulus(input logic [15:0] dvd, input logic [15:0] dvs, input bit holdStart);
        exp_t e;
        exp_t got;
        int   a;
        int   b;
        int   edgeNum;
        a = $signed(dvd);
        b = $signed(dvs);
        if (b == 0) begin
            e.q   = 16'hFFFF;
            e.r   = dvd;
            e.dbz = 1'b1;
            e.lat = 2;
        end else begin
            e.q   = 16'(a / b);
            e.r   = 16'(a % b);
            e.dbz = 1'b0;
            e.lat = 20;
        end
        sb.push_back(e);

        start   = 1'b1;
        data_in = dvd;
        @(posedge clk); #1;
        data_in = dvs;
        start   = holdStart;
        @(posedge clk); #1;
        checkOutput("busy_after_load", {31'd0, busy}, 32'd1);
        if (holdStart) data_in = 16'h1234;
        edgeNum = 1;
        while (!done && edgeNum < 40) begin
            @(posedge clk); #1;
            edgeNum++;
        end
        start = 1'b0;
        checkOutput("done_seen", {31'd0, done}, 32'd1);

        got = sb.pop_front();
        checkOutput("latency", edgeNum, got.lat);
        checkOutput("quotient", {16'd0, quotient}, {16'd0, got.q});
        checkOutput("remainder", {16'd0, remainder}, {16'd0, got.r});
        checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, got.dbz});
        checkOutput("busy_at_done", {31'd0, busy}, 32'd0);

        if (holdStart) begin
            @(posedge clk); #1;
            checkOutput("single_result_done", {31'd0, done}, 32'd1);
            checkOutput("single_result_q", {16'd0, quotient}, {16'd0, got.q});
        end
    endtask

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = 16'd0;
        #12;
        checkOutput("reset_quotient", {16'd0, quotient}, 32'd0);
        checkOutput("reset_remainder", {16'd0, remainder}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("idle_no_start", {31'd0, done | busy}, 32'd0);

        applyStimulus(16'd20, 16'd3, 1'b0);

        // Results must hold in DONE while start stays low
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_done", {31'd0, done}, 32'd1);
        checkOutput("hold_quotient", {16'd0, quotient}, 32'd6);
        checkOutput("hold_remainder", {16'd0, remainder}, 32'd2);

        applyStimulus(-16'sd7, 16'd2, 1'b0);
        applyStimulus(16'd12, -16'sd81, 1'b0);
        applyStimulus(16'h8000, 16'hFFFF, 1'b0);
        applyStimulus(16'h8000, 16'd1, 1'b0);
        applyStimulus(16'd5, 16'd0, 1'b0);
        applyStimulus(-16'sd1234, -16'sd0, 1'b0);
        applyStimulus(16'd100, 16'd7, 1'b1);
        applyStimulus(16'h7FFF, 16'h8000, 1'b0);

        // Reset in the middle of ITER must clear everything immediately
        start   = 1'b1;
        data_in = 16'd1000;
        @(posedge clk); #1;
        data_in = 16'd3;
        start   = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("busy_before_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_quotient", {16'd0, quotient}, 32'd0);
        checkOutput("midreset_remainder", {16'd0, remainder}, 32'd0);
        checkOutput("midreset_done", {31'd0, done}, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_dbz", {31'd0, div_by_zero}, 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("after_reset_idle", {31'd0, busy | done}, 32'd0);

        applyStimulus(16'd9, 16'd4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
